// File: rtl/silent_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : silent_interpolator
// Description : Per-transducer slew limiter. Holds the current intensity and
//               phase of every channel in on-chip memory and moves each one a
//               bounded step toward its target once per frame. The phase path
//               takes the shorter way around the 16-bit circle.
// Revision    : 1.0 - initial release
// ============================================================================
module silent_interpolator #(
  parameter int DEPTH = 249  // channels per frame, 3..256
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [15:0] PHASE_IN,
  input  logic [15:0] UPDATE_RATE_INTENSITY,
  input  logic [15:0] UPDATE_RATE_PHASE,
  output logic [15:0] INTENSITY_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic [7:0]  DOUT_IDX,
  output logic        DOUT_VALID,
  output logic        INIT_DONE
);

  localparam logic [7:0] c_LAST_IDX = 8'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_init_we;
  logic [7:0]  r_init_addr;
  logic [7:0]  r_cnt;
  logic        w_beat;

  logic [15:0] r_mem_int [DEPTH];
  logic [15:0] r_mem_ph  [DEPTH];

  logic        r_s1_valid;
  logic [7:0]  r_s1_idx;
  logic [15:0] r_s1_tgt_int, r_s1_tgt_ph, r_s1_rate_int, r_s1_rate_ph;

  logic        r_s2_valid;
  logic [7:0]  r_s2_idx;
  logic [15:0] r_s2_tgt_int, r_s2_tgt_ph, r_s2_rate_int, r_s2_rate_ph;
  logic [15:0] r_s2_cur_int, r_s2_cur_ph;

  logic [15:0] w_int_up, w_int_dn, w_int_nxt;
  logic [15:0] w_ph_fwd, w_ph_back, w_ph_nxt;

  // Input beats are only accepted once the memories have been cleared.
  assign w_beat = (r_state == ST_RUN) && DIN_VALID;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: INIT clears one address per cycle, then RUN forever.
  always_comb begin
    w_state_nxt = r_state;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_addr == c_LAST_IDX) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Clear-sweep address, channel counter and the done flag.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_init_addr <= 8'd0;
      r_cnt       <= 8'd0;
      INIT_DONE   <= 1'b0;
    end else begin
      INIT_DONE <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + 8'd1;
      if (w_beat) r_cnt <= (r_cnt == c_LAST_IDX) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Single write port: zero-fill during INIT, write-back of S2 results in RUN.
  always_ff @(posedge CLK) begin
    if (w_init_we) begin
      r_mem_int[r_init_addr] <= 16'd0;
      r_mem_ph[r_init_addr]  <= 16'd0;
    end else if (r_s2_valid) begin
      r_mem_int[r_s2_idx] <= w_int_nxt;
      r_mem_ph[r_s2_idx]  <= w_ph_nxt;
    end
  end

  // Pipeline valid bits; cleared by reset so a partial frame is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_beat;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Pipeline data: S1 captures the beat, S2 adds the stored current values.
  always_ff @(posedge CLK) begin
    r_s1_idx      <= r_cnt;
    r_s1_tgt_int  <= INTENSITY_IN;
    r_s1_tgt_ph   <= PHASE_IN;
    r_s1_rate_int <= UPDATE_RATE_INTENSITY;
    r_s1_rate_ph  <= UPDATE_RATE_PHASE;
    r_s2_idx      <= r_s1_idx;
    r_s2_tgt_int  <= r_s1_tgt_int;
    r_s2_tgt_ph   <= r_s1_tgt_ph;
    r_s2_rate_int <= r_s1_rate_int;
    r_s2_rate_ph  <= r_s1_rate_ph;
    r_s2_cur_int  <= r_mem_int[r_s1_idx];
    r_s2_cur_ph   <= r_mem_ph[r_s1_idx];
  end

  // Step computation. Comparing the rate against the remaining distance
  // avoids any overflow and snaps exactly onto the target.
  always_comb begin
    w_int_up  = r_s2_tgt_int - r_s2_cur_int;
    w_int_dn  = r_s2_cur_int - r_s2_tgt_int;
    w_int_nxt = r_s2_cur_int;
    if (r_s2_cur_int < r_s2_tgt_int)
      w_int_nxt = (r_s2_rate_int >= w_int_up) ? r_s2_tgt_int : r_s2_cur_int + r_s2_rate_int;
    else if (r_s2_cur_int > r_s2_tgt_int)
      w_int_nxt = (r_s2_rate_int >= w_int_dn) ? r_s2_tgt_int : r_s2_cur_int - r_s2_rate_int;

    // Phase wraps; a half-turn distance (0x8000) is treated as backward.
    w_ph_fwd  = r_s2_tgt_ph - r_s2_cur_ph;
    w_ph_back = 16'd0 - w_ph_fwd;
    w_ph_nxt  = r_s2_cur_ph;
    if (w_ph_fwd != 16'd0) begin
      if (!w_ph_fwd[15])
        w_ph_nxt = r_s2_cur_ph + ((r_s2_rate_ph < w_ph_fwd) ? r_s2_rate_ph : w_ph_fwd);
      else
        w_ph_nxt = r_s2_cur_ph - ((r_s2_rate_ph < w_ph_back) ? r_s2_rate_ph : w_ph_back);
    end
  end

  // Output register; values hold between beats.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      DOUT_VALID    <= 1'b0;
      INTENSITY_OUT <= 16'd0;
      PHASE_OUT     <= 8'd0;
      DOUT_IDX      <= 8'd0;
    end else begin
      DOUT_VALID <= r_s2_valid;
      if (r_s2_valid) begin
        INTENSITY_OUT <= w_int_nxt;
        PHASE_OUT     <= w_ph_nxt[15:8];
        DOUT_IDX      <= r_s2_idx;
      end
    end
  end

endmodule
`default_nettype wire
